// File: rtl/register_file_pkg.sv
// Shared definitions for the register file: data width, operation codes and
// the 3-bit register index codes used by the read multiplexers.
package register_file_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;

  // Operation applied to every enabled register on the rising clock edge.
  typedef enum logic [1:0] {
    FS_DEC  = 2'b00,
    FS_INC  = 2'b01,
    FS_LOAD = 2'b10,
    FS_CLR  = 2'b11
  } funsel_e;

  // Read-select codes; the numeric value is also the storage slot index.
  typedef enum logic [2:0] {
    IDX_R1 = 3'b000,
    IDX_R2 = 3'b001,
    IDX_R3 = 3'b010,
    IDX_R4 = 3'b011,
    IDX_S1 = 3'b100,
    IDX_S2 = 3'b101,
    IDX_S3 = 3'b110,
    IDX_S4 = 3'b111
  } reg_idx_e;

endpackage

// File: rtl/reg16_cell.sv
// One 16-bit register: decrement, increment, load or clear when enabled,
// cleared by synchronous reset regardless of enable.
module reg16_cell
  import register_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              E,
  input  logic [1:0]        FunSel,
  input  logic [DATA_W-1:0] I,
  output logic [DATA_W-1:0] Q
);

  // Register update: reset wins, otherwise apply FunSel when enabled, else hold.
  // NOTE: non-blocking assignments keep every cell updating from pre-edge values,
  // so simultaneous writes and reads of the same edge never race.
  always_ff @(posedge clk) begin
    if (rst) begin
      Q <= '0;
    end else if (E) begin
      case (FunSel)
        FS_DEC:  Q <= Q - 1'b1;  // wraps 0x0000 -> 0xFFFF, borrow discarded
        FS_INC:  Q <= Q + 1'b1;  // wraps 0xFFFF -> 0x0000, carry discarded
        FS_LOAD: Q <= I;
        FS_CLR:  Q <= '0;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/register_file.sv
// Eight-entry register file (R1..R4 general, S1..S4 scratch) with a shared
// operation/data bus and two independent combinational read ports.
module register_file
  import register_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] I,
  input  logic [1:0]        FunSel,
  input  logic [3:0]        RegSel,
  input  logic [3:0]        ScrSel,
  input  logic [2:0]        OutASel,
  input  logic [2:0]        OutBSel,
  output logic [DATA_W-1:0] OutA,
  output logic [DATA_W-1:0] OutB
);

  // Slot order matches the index codes: R1..R4 in 0..3, S1..S4 in 4..7.
  logic [NUM_REGS-1:0] en;
  logic [DATA_W-1:0]   q [NUM_REGS];

  assign en = {ScrSel, RegSel};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    reg16_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .E      (en[g]),
      .FunSel (FunSel),
      .I      (I),
      .Q      (q[g])
    );
  end

  // Read port A: plain mux of current register state, no write bypass.
  // NOTE: the default assignment ahead of the case guarantees OutA is driven on
  // every path, so no latch can be inferred even if the case were incomplete.
  always_comb begin
    OutA = '0;
    case (OutASel)
      IDX_R1:  OutA = q[0];
      IDX_R2:  OutA = q[1];
      IDX_R3:  OutA = q[2];
      IDX_R4:  OutA = q[3];
      IDX_S1:  OutA = q[4];
      IDX_S2:  OutA = q[5];
      IDX_S3:  OutA = q[6];
      IDX_S4:  OutA = q[7];
      default: OutA = '0;
    endcase
  end

  // Read port B: identical structure to port A.
  always_comb begin
    OutB = '0;
    case (OutBSel)
      IDX_R1:  OutB = q[0];
      IDX_R2:  OutB = q[1];
      IDX_R3:  OutB = q[2];
      IDX_R4:  OutB = q[3];
      IDX_S1:  OutB = q[4];
      IDX_S2:  OutB = q[5];
      IDX_S3:  OutB = q[6];
      IDX_S4:  OutB = q[7];
      default: OutB = '0;
    endcase
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [15:0] I;
  logic [1:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic [15:0] OutA;
  logic [15:0] OutB;

  int passed = 0;
  int total  = 0;

  register_file dut (
    .clk     (clk),
    .rst     (rst),
    .I       (I),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .ScrSel  (ScrSel),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .OutA    (OutA),
    .OutB    (OutB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegSel = 4'b0000;
    ScrSel = 4'b0000;
    FunSel = 2'b01;
    I      = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 8; s++) begin
      OutASel = 3'(s);
      OutBSel = 3'(7 - s);
      #1;
      total++;
      if (OutA !== 16'h0000) $display("FAIL reset_outa sel=%0d: got %h expected 0000", s, OutA);
      else passed++;
      total++;
      if (OutB !== 16'h0000) $display("FAIL reset_outb sel=%0d: got %h expected 0000", 7 - s, OutB);
      else passed++;
    end
  endtask

  task automatic test_load_read();
    RegSel = 4'b0001; FunSel = 2'b10; I = 16'h1234;
    tick();
    idle();
    OutASel = 3'b000;
    #1;
    total++;
    if (OutA !== 16'h1234) $display("FAIL load_r1: got %h expected 1234", OutA);
    else passed++;
    for (int s = 1; s < 8; s++) begin
      OutBSel = 3'(s);
      #1;
      total++;
      if (OutB !== 16'h0000) $display("FAIL load_others sel=%0d: got %h expected 0000", s, OutB);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    OutASel = 3'b001;
    RegSel = 4'b0010; FunSel = 2'b10; I = 16'hFFFF;
    tick();
    total++;
    if (OutA !== 16'hFFFF) $display("FAIL wrap_load_r2: got %h expected ffff", OutA);
    else passed++;
    FunSel = 2'b01;
    tick();
    total++;
    if (OutA !== 16'h0000) $display("FAIL wrap_inc_r2: got %h expected 0000", OutA);
    else passed++;
    FunSel = 2'b00;
    tick();
    total++;
    if (OutA !== 16'hFFFF) $display("FAIL wrap_dec_r2: got %h expected ffff", OutA);
    else passed++;
    idle();
    // R1 must have held through the R2-only operations.
    OutBSel = 3'b000;
    #1;
    total++;
    if (OutB !== 16'h1234) $display("FAIL wrap_r1_hold: got %h expected 1234", OutB);
    else passed++;
  endtask

  task automatic test_read_during_write();
    ScrSel = 4'b0100; FunSel = 2'b10; I = 16'h0007;
    tick();
    FunSel = 2'b01; I = 16'h0000;
    OutBSel = 3'b110;
    #1;
    total++;
    if (OutB !== 16'h0007) $display("FAIL rdw_before_edge: got %h expected 0007", OutB);
    else passed++;
    tick();
    idle();
    total++;
    if (OutB !== 16'h0008) $display("FAIL rdw_after_edge: got %h expected 0008", OutB);
    else passed++;
    OutASel = 3'b110;
    #1;
    total++;
    if (OutA !== 16'h0008 || OutB !== 16'h0008)
      $display("FAIL same_reg: got A=%h B=%h expected 0008/0008", OutA, OutB);
    else passed++;
  endtask

  task automatic test_hold();
    logic [15:0] exp_v [8];
    exp_v = '{16'h1234, 16'hFFFF, 16'h0000, 16'h0000,
              16'h0000, 16'h0000, 16'h0008, 16'h0000};
    idle();
    FunSel = 2'b01;
    I = 16'hBEEF;
    repeat (5) tick();
    for (int s = 0; s < 8; s++) begin
      OutASel = 3'(s);
      #1;
      total++;
      if (OutA !== exp_v[s]) $display("FAIL hold sel=%0d: got %h expected %h", s, OutA, exp_v[s]);
      else passed++;
    end
  endtask

  task automatic test_clear_and_dec();
    // Clear R1 only; decrement S4 from zero.
    RegSel = 4'b0001; FunSel = 2'b11;
    tick();
    idle();
    ScrSel = 4'b1000; FunSel = 2'b00;
    tick();
    idle();
    OutASel = 3'b000; OutBSel = 3'b111;
    #1;
    total++;
    if (OutA !== 16'h0000) $display("FAIL clr_r1: got %h expected 0000", OutA);
    else passed++;
    total++;
    if (OutB !== 16'hFFFF) $display("FAIL dec_wrap_s4: got %h expected ffff", OutB);
    else passed++;
    OutASel = 3'b001;
    #1;
    total++;
    if (OutA !== 16'hFFFF) $display("FAIL clr_r2_untouched: got %h expected ffff", OutA);
    else passed++;
  endtask

  task automatic test_multi_enable();
    RegSel = 4'b1111; ScrSel = 4'b1111; FunSel = 2'b10; I = 16'hA5A5;
    tick();
    idle();
    for (int s = 0; s < 8; s++) begin
      OutASel = 3'(s);
      OutBSel = 3'(s);
      #1;
      total++;
      if (OutA !== 16'hA5A5) $display("FAIL multi_outa sel=%0d: got %h expected a5a5", s, OutA);
      else passed++;
      total++;
      if (OutB !== 16'hA5A5) $display("FAIL multi_outb sel=%0d: got %h expected a5a5", s, OutB);
      else passed++;
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    RegSel = 4'b1111; ScrSel = 4'b1111; FunSel = 2'b10; I = 16'hFFFF;
    tick();
    rst = 1'b0;
    idle();
    for (int s = 0; s < 8; s++) begin
      OutASel = 3'(s);
      OutBSel = 3'(7 - s);
      #1;
      total++;
      if (OutA !== 16'h0000 || OutB !== 16'h0000)
        $display("FAIL rst_priority sel=%0d: got A=%h B=%h expected 0000/0000", s, OutA, OutB);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    OutASel = 3'b000;
    OutBSel = 3'b000;
    idle();
    test_reset();
    test_load_read();
    test_wrap();
    test_read_during_write();
    test_hold();
    test_clear_and_dec();
    test_multi_enable();
    test_reset_priority();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
